// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback (priority) and buffered MDU results.
// Optional macro STARVE_GUARD_EN: forces a waiting FIFO head in after STARVE_MAX cycles by stalling WB.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic        iss_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end
    if (STARVE_MAX < 1) begin : g_starve_check
        $error("STARVE_MAX must be at least 1");
    end

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic          fifo_nonempty;
    logic          force_pop;
    logic          pipe_req;
    logic          pop;
    logic          push;
    logic          issue;

    assign head_addr     = fifo_addr[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];
    assign fifo_nonempty = (count != '0);

`ifdef STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_MAX + 1);
    logic [WW-1:0] wait_cnt;

    assign force_pop = fifo_nonempty && (wait_cnt == WW'(STARVE_MAX));

    // Counts consecutive cycles the head has been passed over by the pipeline.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!fifo_nonempty || pop) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    assign force_pop = 1'b0;
`endif

    assign wb_stall = force_pop;

    // Gating with reset keeps the write port quiet while reset is held, even if WB requests.
    assign pipe_req  = reset && wb_we && (wb_addr != 5'd0) && !wb_stall;
    assign pop       = reset && !pipe_req && fifo_nonempty;
    assign mdu_ready = (count < DEPTH_C);
    assign push      = mdu_valid && mdu_ready;
    assign iss_ready = !busy[iss_addr] && (outstanding < DEPTH_C);
    assign issue     = iss_valid && iss_ready;
    assign rs_busy   = busy[rs_addr];
    assign rt_busy   = busy[rt_addr];

    always_comb begin
        WE3 = 1'b0;
        A3  = 5'd0;
        WD3 = 32'd0;
        if (pipe_req) begin
            WE3 = 1'b1;
            A3  = wb_addr;
            WD3 = wb_data;
        end else if (pop && head_addr != 5'd0) begin
            WE3 = 1'b1;
            A3  = head_addr;
            WD3 = head_data;
        end
    end

    // Pop clears before issue sets; a same-address issue cannot coincide since busy gates it.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head_addr] = 1'b0;
        end
        if (issue && iss_addr != 5'd0) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            busy        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(issue) - CW'(pop);
            busy        <= busy_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based model predicts each cycle's write and handshakes.
// Works with or without STARVE_GUARD_EN defined.
module tb_regfile_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        wb_we, iss_valid, mdu_valid;
    logic [4:0]  wb_addr, iss_addr, mdu_addr, rs_addr, rt_addr;
    logic [31:0] wb_data, mdu_data;
    logic        wb_stall, iss_ready, mdu_ready, rs_busy, rt_busy, WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t      model_fifo[$];
    entry_t      exp_q[$];
    logic [4:0]  inflight[$];
    logic [31:0] model_busy = '0;
    int          model_out = 0;
    int          model_wait = 0;
    int          errors = 0;
    int          checks = 0;

    logic        nxt_we, nxt_iv, nxt_mv;
    logic [4:0]  nxt_wa, nxt_ia, nxt_ma, nxt_ra, nxt_rb;
    logic [31:0] nxt_wd, nxt_md;
    logic        last_iss_acc, last_mdu_acc;
    entry_t      mon_e;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stim();
        nxt_we = 1'b0; nxt_wa = '0; nxt_wd = '0;
        nxt_iv = 1'b0; nxt_ia = '0;
        nxt_mv = 1'b0; nxt_ma = '0; nxt_md = '0;
        nxt_ra = '0;   nxt_rb = '0;
    endtask

    // One clock of stimulus: predict from the model, advance the model, check handshakes mid-cycle.
    task automatic apply_stimulus();
        logic   stall_e, iss_rdy_e, mdu_rdy_e, rs_e, rt_e, pipe, popped;
        int     size0;
        entry_t h;
        @(posedge CLK);
        #1;
        wb_we = nxt_we; wb_addr = nxt_wa; wb_data = nxt_wd;
        iss_valid = nxt_iv; iss_addr = nxt_ia;
        mdu_valid = nxt_mv; mdu_addr = nxt_ma; mdu_data = nxt_md;
        rs_addr = nxt_ra; rt_addr = nxt_rb;

        size0   = model_fifo.size();
        stall_e = 1'b0;
`ifdef STARVE_GUARD_EN
        stall_e = (size0 > 0) && (model_wait == STARVE_MAX);
`endif
        iss_rdy_e = !model_busy[nxt_ia] && (model_out < DEPTH);
        mdu_rdy_e = (size0 < DEPTH);
        rs_e      = model_busy[nxt_ra];
        rt_e      = model_busy[nxt_rb];
        pipe      = nxt_we && (nxt_wa != 5'd0) && !stall_e;
        popped    = 1'b0;

        if (pipe) begin
            exp_q.push_back('{addr: nxt_wa, data: nxt_wd});
        end else if (size0 > 0) begin
            h = model_fifo.pop_front();
            popped = 1'b1;
            if (h.addr != 5'd0) exp_q.push_back(h);
            model_busy[h.addr] = 1'b0;
            model_out--;
        end
        last_mdu_acc = nxt_mv && mdu_rdy_e;
        if (last_mdu_acc) model_fifo.push_back('{addr: nxt_ma, data: nxt_md});
        last_iss_acc = nxt_iv && iss_rdy_e;
        if (last_iss_acc) begin
            if (nxt_ia != 5'd0) model_busy[nxt_ia] = 1'b1;
            model_out++;
        end
        model_wait = (size0 == 0 || popped) ? 0 : model_wait + 1;

        @(negedge CLK);
        check_output("wb_stall", wb_stall, stall_e);
        check_output("iss_ready", iss_ready, iss_rdy_e);
        check_output("mdu_ready", mdu_ready, mdu_rdy_e);
        check_output("rs_busy", rs_busy, rs_e);
        check_output("rt_busy", rt_busy, rt_e);
    endtask

    // Asserts reset between edges and checks that outputs collapse immediately.
    task automatic apply_reset(input logic [4:0] probe);
        @(posedge CLK);
        #1;
        clear_stim();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
        rs_addr = probe; rt_addr = probe;
        reset = 1'b0;
        #1;
        check_output("rst_WE3", WE3, 1'b0);
        check_output("rst_A3", A3, 5'd0);
        check_output("rst_rs_busy", rs_busy, 1'b0);
        check_output("rst_mdu_ready", mdu_ready, 1'b1);
        check_output("rst_iss_ready", iss_ready, 1'b1);
        check_output("rst_wb_stall", wb_stall, 1'b0);
        model_fifo.delete();
        exp_q.delete();
        inflight.delete();
        model_busy = '0;
        model_out  = 0;
        model_wait = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every cycle the write port must match the predicted write, or be idle.
    always @(negedge CLK) begin
        if (reset) begin
            checks++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                if (!WE3 || A3 !== mon_e.addr || WD3 !== mon_e.data) begin
                    errors++;
                    $display("[TB] FAIL write: got we=%b a=%0d d=%0h expected a=%0d d=%0h at %0t",
                             WE3, A3, WD3, mon_e.addr, mon_e.data, $time);
                end
            end else if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin
                errors++;
                $display("[TB] FAIL idle_port: got we=%b a=%0d d=%0h expected idle at %0t",
                         WE3, A3, WD3, $time);
            end
        end
    end

    initial begin
        clear_stim();
        apply_reset(5'd0);

        // Pipeline write passes straight through
        clear_stim(); nxt_we = 1'b1; nxt_wa = 5'd5; nxt_wd = 32'hDEADBEEF; apply_stimulus();

        // Issue, refused re-issue, result, busy release
        clear_stim(); nxt_iv = 1'b1; nxt_ia = 5'd9; nxt_ra = 5'd9; apply_stimulus();
        apply_stimulus();
        clear_stim(); nxt_ra = 5'd9; nxt_mv = 1'b1; nxt_ma = 5'd9; nxt_md = 32'h1234; apply_stimulus();
        nxt_mv = 1'b0; apply_stimulus();
        apply_stimulus();

        // Fill outstanding and FIFO while WB holds the port, then drain
        clear_stim();
        for (int i = 0; i < 4; i++) begin
            nxt_iv = 1'b1; nxt_ia = 5'(10 + i); apply_stimulus();
        end
        nxt_ia = 5'd14; apply_stimulus();
        clear_stim(); nxt_we = 1'b1; nxt_wa = 5'd3; nxt_wd = 32'h333; nxt_rb = 5'd12;
        for (int i = 0; i < 4; i++) begin
            nxt_mv = 1'b1; nxt_ma = 5'(10 + i); nxt_md = 32'(256 + i); apply_stimulus();
        end
        nxt_ma = 5'd14; apply_stimulus();
        clear_stim(); nxt_ia = 5'd14; nxt_rb = 5'd12;
        repeat (6) apply_stimulus();

        // WB to register 0 does not block a pop
        clear_stim(); nxt_iv = 1'b1; nxt_ia = 5'd7; apply_stimulus();
        clear_stim(); nxt_we = 1'b1; nxt_wa = 5'd3; nxt_wd = 32'h1;
        nxt_mv = 1'b1; nxt_ma = 5'd7; nxt_md = 32'hAA; apply_stimulus();
        nxt_mv = 1'b0; nxt_wa = 5'd0; apply_stimulus();

        // Issue and result to register 0: slot consumed, nothing written
        clear_stim(); nxt_iv = 1'b1; nxt_ia = 5'd0; apply_stimulus();
        clear_stim(); nxt_mv = 1'b1; nxt_ma = 5'd0; nxt_md = 32'h77; apply_stimulus();
        clear_stim(); apply_stimulus(); apply_stimulus();

        // Head waiting behind continuous WB writes
        clear_stim(); nxt_iv = 1'b1; nxt_ia = 5'd2; apply_stimulus();
        clear_stim(); nxt_we = 1'b1; nxt_wa = 5'd6; nxt_wd = 32'h66; nxt_ra = 5'd2;
        nxt_mv = 1'b1; nxt_ma = 5'd2; nxt_md = 32'h55; apply_stimulus();
        nxt_mv = 1'b0;
        repeat (12) apply_stimulus();
        clear_stim(); nxt_ra = 5'd2; apply_stimulus(); apply_stimulus();

        // Reset with results pending and busy bits set
        clear_stim();
        for (int i = 0; i < 3; i++) begin
            nxt_iv = 1'b1; nxt_ia = 5'(20 + i); apply_stimulus();
        end
        clear_stim(); nxt_we = 1'b1; nxt_wa = 5'd3; nxt_wd = 32'h99;
        for (int i = 0; i < 3; i++) begin
            nxt_mv = 1'b1; nxt_ma = 5'(20 + i); nxt_md = 32'(4096 + i); apply_stimulus();
        end
        apply_reset(5'd20);
        clear_stim(); nxt_ra = 5'd20; nxt_rb = 5'd21;
        repeat (4) apply_stimulus();

        // Randomized traffic: results return for issued destinations in issue order
        for (int n = 0; n < 400; n++) begin
            clear_stim();
            nxt_we = ($urandom_range(0, 99) < 40);
            nxt_wa = 5'($urandom_range(0, 31));
            nxt_wd = $urandom;
            nxt_iv = 1'($urandom_range(0, 1));
            nxt_ia = 5'($urandom_range(0, 7));
            if (inflight.size() > 0 && $urandom_range(0, 99) < 60) begin
                nxt_mv = 1'b1;
                nxt_ma = inflight[0];
                nxt_md = $urandom;
            end
            nxt_ra = 5'($urandom_range(0, 7));
            nxt_rb = 5'($urandom_range(0, 7));
            apply_stimulus();
            if (last_mdu_acc) void'(inflight.pop_front());
            if (last_iss_acc) inflight.push_back(nxt_ia);
        end

        clear_stim();
        repeat (8) apply_stimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
